// File: rtl/fpga_board_pkg.sv
// Board-level constants shared by the FPGA wrappers: reference clock and debounce defaults.
// Pure constants; no logic, no latency.
package fpga_board_pkg;

  localparam int unsigned REF_CLK_HZ  = 125_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int unsigned DEBOUNCE_CYCLES_DFLT = ms_to_cycles(REF_CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned SYNC_STAGES_DFLT     = 2;

endpackage

// File: rtl/fpga_debounce_ch.sv
// One input channel: synchroniser chain, debounce counter, clean/prev flops and edge pulses.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges (SYNC_STAGES+1 when bypassed); no backpressure.
module fpga_debounce_ch
  import fpga_board_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DFLT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter logic        RESET_VAL       = 1'b0,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic bypass,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   prev;
  logic [CNT_W-1:0]       cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Counter only runs while sync disagrees with clean, so it clears before it can wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean <= RESET_VAL;
      cnt   <= '0;
    end else if (bypass) begin
      clean <= sync;
      cnt   <= '0;
    end else if (sync == clean) begin
      cnt   <= '0;
    end else if (cnt == CNT_LAST) begin
      clean <= sync;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= RESET_VAL;
    end else begin
      prev <= clean;
    end
  end

  assign rise   = clean & ~prev;
  assign fall   = ~clean & prev;
  assign stable = (cnt == '0);

endmodule

// File: rtl/fpga_input_conditioner.sv
// NUM_CH independent synchronise+debounce channels for board pads, with per-channel bypass and events.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges (SYNC_STAGES+1 bypassed); no backpressure, pulses are one cycle.
module fpga_input_conditioner
  import fpga_board_pkg::*;
#(
  parameter int unsigned       NUM_CH          = 8,
  parameter int unsigned       SYNC_STAGES     = SYNC_STAGES_DFLT,
  parameter int unsigned       DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter logic [NUM_CH-1:0] RESET_VAL       = '0,
  parameter int unsigned       CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              ref_clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] raw_i,
  input  logic [NUM_CH-1:0] bypass_i,
  output logic [NUM_CH-1:0] clean_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] stable_o,
  output logic              any_event_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fpga_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (RESET_VAL[g]),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk   (ref_clk_i),
      .rst_n (rst_ni),
      .raw   (raw_i[g]),
      .bypass(bypass_i[g]),
      .clean (clean_o[g]),
      .rise  (rise_o[g]),
      .fall  (fall_o[g]),
      .stable(stable_o[g])
    );
  end

  assign any_event_o = |(rise_o | fall_o);

endmodule
